// File: rtl/pid_pwm_if.sv
// Bundle of the run-enable, PID sample input and PWM/status outputs of the pid_pwm stage.
// The slave modport is the PWM stage itself; the master side drives en/uk0 and watches the rest.
interface pid_pwm_if #(
    parameter int CW = 10
);
    logic          en;
    logic [16:0]   uk0;
    logic          pwm_out;
    logic          period_tick;
    logic [CW-1:0] duty;
    logic          sat_hi;
    logic          sat_lo;
    logic [1:0]    state;

    modport master (
        output en,
        output uk0,
        input  pwm_out,
        input  period_tick,
        input  duty,
        input  sat_hi,
        input  sat_lo,
        input  state
    );

    modport slave (
        input  en,
        input  uk0,
        output pwm_out,
        output period_tick,
        output duty,
        output sat_hi,
        output sat_lo,
        output state
    );
endinterface

// File: rtl/pid_pwm.sv
// PWM output stage behind the PID loop: samples and clamps uk0 once per period, soft-starts
// the duty with a per-period slew limit, and emits the period strobe used as the loop tick.
module pid_pwm #(
    parameter int PERIOD = 1000,
    parameter int CW     = 10,
    parameter int SLEW   = 16
) (
    input  logic     clk,
    input  logic     rst,
    pid_pwm_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2
    } pwmState_t;

    localparam logic [CW-1:0]     LAST_CNT  = CW'(PERIOD - 1);
    localparam logic [CW-1:0]     FULL_DUTY = CW'(PERIOD);
    localparam logic signed [16:0] PERIOD_S = 17'(PERIOD);
    localparam logic signed [CW:0] SLEW_S   = (CW+1)'(SLEW);

    pwmState_t r_state;
    pwmState_t w_nextState;

    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       r_duty;
    logic                r_pwm;
    logic                r_satHi;
    logic                r_satLo;

    logic                w_active;
    logic                w_tick;
    logic signed [16:0]  w_uk0;
    logic                w_clampLo;
    logic                w_clampHi;
    logic [CW-1:0]       w_target;
    logic signed [CW:0]  w_diff;
    logic [CW-1:0]       w_rampDuty;
    logic [CW-1:0]       w_newDuty;

    // Clamp is evaluated in full signed width so large positive/negative samples cannot alias.
    assign w_uk0     = signed'(bus.uk0);
    assign w_clampLo = (w_uk0 < 17'sd0);
    assign w_clampHi = (w_uk0 > PERIOD_S);

    always_comb begin
        w_target = bus.uk0[CW-1:0];
        if (w_clampLo) begin
            w_target = '0;
        end else if (w_clampHi) begin
            w_target = FULL_DUTY;
        end
    end

    assign w_diff = signed'({1'b0, w_target}) - signed'({1'b0, r_duty});

    always_comb begin
        w_rampDuty = w_target;
        if (w_diff > SLEW_S) begin
            w_rampDuty = r_duty + CW'(SLEW);
        end else if (w_diff < -SLEW_S) begin
            w_rampDuty = r_duty - CW'(SLEW);
        end
    end

    assign w_newDuty = (r_state == RUN) ? w_target : w_rampDuty;
    assign w_active  = (r_state == RAMP) || (r_state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = IDLE;
        case (r_state)
            IDLE: begin
                w_nextState = bus.en ? RAMP : IDLE;
            end
            RAMP: begin
                if (bus.en) begin
                    w_nextState = (w_tick && (w_rampDuty == w_target)) ? RUN : RAMP;
                end
            end
            RUN: begin
                if (bus.en) begin
                    w_nextState = RUN;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        w_tick          = w_active && (r_cnt == LAST_CNT);
        bus.period_tick = w_tick;
        bus.state       = r_state;
        bus.pwm_out     = r_pwm;
        bus.duty        = r_duty;
        bus.sat_hi      = r_satHi;
        bus.sat_lo      = r_satLo;
    end

    // Dropping en clears everything at once so a re-enable always restarts the ramp from zero.
    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            r_cnt   <= '0;
            r_duty  <= '0;
            r_pwm   <= 1'b0;
            r_satHi <= 1'b0;
            r_satLo <= 1'b0;
        end else if (!w_active) begin
            r_cnt   <= '0;
            r_duty  <= '0;
            r_pwm   <= 1'b0;
            r_satHi <= 1'b0;
            r_satLo <= 1'b0;
        end else begin
            r_pwm <= (r_cnt < r_duty);
            if (r_cnt == LAST_CNT) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_tick) begin
                r_duty  <= w_newDuty;
                r_satHi <= w_clampHi;
                r_satLo <= w_clampLo;
            end
        end
    end
endmodule
